// File: rtl/adder_rr_scheduler_pkg.sv
// Shared types and default constants for the round-robin adder scheduler.
package adder_rr_scheduler_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned DEF_N         = 25;
  localparam int unsigned DEF_NREQ      = 4;
  localparam int unsigned DEF_MAX_BURST = 20;

endpackage

// File: rtl/adder_rr_scheduler_adder.sv
// Existing combinational adder; carry out of the top bit is discarded.
module adder
  import adder_rr_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_N
) (
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] sum
);

  assign sum = input1 + input2;

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin packet arbiter feeding one shared adder with a registered,
// backpressured result stage.
module adder_rr_scheduler
  import adder_rr_scheduler_pkg::*;
#(
  parameter  int unsigned N         = DEF_N,
  parameter  int unsigned NREQ      = DEF_NREQ,
  parameter  int unsigned MAX_BURST = DEF_MAX_BURST,
  localparam int unsigned ID_W      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*N-1:0] req_op1,
  input  logic [NREQ*N-1:0] req_op2,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_sum,
  output logic [ID_W-1:0]   res_id,
  output logic              res_last,
  output logic              busy,
  output logic [31:0]       flit_cnt
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              res_valid_q, res_valid_d;
  logic [N-1:0]      res_sum_q, res_sum_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_last_q, res_last_d;
  logic [31:0]       flit_cnt_q, flit_cnt_d;

  logic              accept, xfer, release_now, found;
  logic [ID_W-1:0]   pick;
  int unsigned       cand;
  logic [N-1:0]      op1, op2, sum;

  // Cyclic search starting at rr_ptr; first hit wins.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    cand  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_valid[ID_W'(cand)]) begin
        found = 1'b1;
        pick  = ID_W'(cand);
      end
    end
  end

  always_comb begin
    op1 = req_op1[owner_q*N +: N];
    op2 = req_op2[owner_q*N +: N];
  end

  adder #(.WIDTH(N)) u_adder (
    .input1 (op1),
    .input2 (op2),
    .sum    (sum)
  );

  assign accept      = (state_q == LOCKED) && (!res_valid_q || res_ready);
  assign req_ready   = accept ? (NREQ'(1) << owner_q) : '0;
  assign xfer        = accept && req_valid[owner_q];
  assign release_now = xfer && (req_last[owner_q] ||
                                (32'(burst_cnt_q) + 32'd1 == MAX_BURST));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d     = pick;
          burst_cnt_d = '0;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (release_now) begin
            state_d  = IDLE;
            rr_ptr_d = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A transfer overwrites the result even if it is being drained this cycle.
  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    res_last_d  = res_last_q;
    flit_cnt_d  = flit_cnt_q;
    if (xfer) begin
      res_valid_d = 1'b1;
      res_sum_d   = sum;
      res_id_d    = owner_q;
      res_last_d  = req_last[owner_q];
      flit_cnt_d  = flit_cnt_q + 32'd1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      res_last_q  <= 1'b0;
      flit_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      res_last_q  <= res_last_d;
      flit_cnt_q  <= flit_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign res_last  = res_last_q;
  assign busy      = (state_q == LOCKED);
  assign flit_cnt  = flit_cnt_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// behavioural grant/result model.
module tb_adder_rr_scheduler;

  localparam int N = 25, NREQ = 4, MAXB = 20, IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_last, req_ready;
  logic [NREQ*N-1:0] req_op1, req_op2;
  logic              res_valid, res_ready, res_last, busy;
  logic [N-1:0]      res_sum;
  logic [IDW-1:0]    res_id;
  logic [31:0]       flit_cnt;

  int checks = 0, errors = 0;

  adder_rr_scheduler #(.N(N), .NREQ(NREQ), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_op1(req_op1), .req_op2(req_op2), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_id(res_id), .res_last(res_last), .busy(busy), .flit_cnt(flit_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: grant holder, pointer, flits in grant, result slot.
  bit          m_locked, m_rv, m_last;
  int          m_owner, m_ptr, m_burst, m_id;
  logic [N-1:0] m_sum;
  logic [31:0] m_flits;

  // Traffic sources.
  int          src_left[NREQ];
  bit          src_nolast[NREQ], src_hold[NREQ], src_single[NREQ];
  bit          src_rand, sb_on;
  logic [N-1:0] s_op1[NREQ], s_op2[NREQ];
  logic [N-1:0] sb_q[$];

  function automatic logic [NREQ-1:0] m_ready_f();
    logic [NREQ-1:0] r;
    r = '0;
    if (m_locked && (!m_rv || res_ready)) r[m_owner] = 1'b1;
    return r;
  endfunction

  task automatic model_edge(output int xk);
    longint unsigned s;
    bit found;
    xk = -1;
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_burst = 0;
      m_rv = 0; m_sum = '0; m_id = 0; m_last = 0; m_flits = '0;
      return;
    end
    if (m_locked && (!m_rv || res_ready) && req_valid[m_owner]) xk = m_owner;
    if (xk >= 0) begin
      s = longint'(req_op1[xk*N +: N]) + longint'(req_op2[xk*N +: N]);
      m_sum  = N'(s % (64'd1 << N));
      m_rv   = 1; m_id = xk; m_last = req_last[xk];
      m_flits = m_flits + 1;
    end else if (res_ready) begin
      m_rv = 0;
    end
    if (!m_locked) begin
      found = 0;
      for (int i = 0; i < NREQ; i++) begin
        int c;
        c = (m_ptr + i) % NREQ;
        if (!found && req_valid[c]) begin found = 1; m_owner = c; end
      end
      if (found) begin m_burst = 0; m_locked = 1; end
    end else if (xk >= 0) begin
      m_burst++;
      if (req_last[xk] || m_burst == MAXB) begin
        m_locked = 0;
        m_ptr = (xk + 1) % NREQ;
      end
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NREQ; k++) begin
      req_valid[k] = (src_left[k] > 0) && !src_hold[k];
      req_last[k]  = !src_nolast[k] && (src_single[k] || src_left[k] == 1);
      req_op1[k*N +: N] = s_op1[k];
      req_op2[k*N +: N] = s_op2[k];
    end
  endtask

  task automatic tick();
    int xk;
    longint unsigned s;
    @(posedge clk);
    model_edge(xk);
    if (xk >= 0) begin
      if (sb_on) begin
        s = longint'(s_op1[xk]) + longint'(s_op2[xk]);
        sb_q.push_back(N'(s % (64'd1 << N)));
      end
      src_left[xk]--;
      if (src_rand) begin s_op1[xk] = N'($urandom); s_op2[xk] = N'($urandom); end
    end
    #1;
    drive_inputs();
  endtask

  task automatic clear_sources();
    for (int k = 0; k < NREQ; k++) begin
      src_left[k] = 0; src_nolast[k] = 0; src_hold[k] = 0; src_single[k] = 0;
      s_op1[k] = '0; s_op2[k] = '0;
    end
    src_rand = 0; sb_on = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_sources(); res_ready = 1; drive_inputs();
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks += 7;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    if (res_sum !== '0) begin errors++; $display("FAIL rst_res_sum got %h want 0", res_sum); end
    if (res_id !== '0) begin errors++; $display("FAIL rst_res_id got %h want 0", res_id); end
    if (res_last !== 1'b0) begin errors++; $display("FAIL rst_res_last got %b want 0", res_last); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (flit_cnt !== 32'd0) begin errors++; $display("FAIL rst_flit_cnt got %0d want 0", flit_cnt); end
    if (req_ready !== '0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    tick();
  endtask

  task automatic test_single_packet();
    logic [N-1:0] sums[$];
    logic [IDW-1:0] ids[$];
    logic lasts[$];
    logic [NREQ-1:0] exp;
    do_reset();
    src_left[0] = 3; s_op1[0] = 25'h0000001; s_op2[0] = 25'h0000002;
    drive_inputs();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp = (c >= 2 && c <= 4) ? 4'b0001 : 4'b0000;
      checks++;
      if (req_ready !== exp) begin errors++; $display("FAIL single_ready c%0d got %b want %b", c, req_ready, exp); end
      if (res_valid === 1'b1) begin sums.push_back(res_sum); ids.push_back(res_id); lasts.push_back(res_last); end
      tick();
    end
    checks++;
    if (sums.size() != 3) begin errors++; $display("FAIL single_count got %0d want 3", sums.size()); end
    for (int i = 0; i < sums.size() && i < 3; i++) begin
      checks += 3;
      if (sums[i] !== 25'h0000003) begin errors++; $display("FAIL single_sum%0d got %h want 0000003", i, sums[i]); end
      if (ids[i] !== 2'd0) begin errors++; $display("FAIL single_id%0d got %0d want 0", i, ids[i]); end
      if (lasts[i] !== (i == 2)) begin errors++; $display("FAIL single_last%0d got %b want %b", i, lasts[i], i == 2); end
    end
    @(negedge clk);
    checks++;
    if (flit_cnt !== 32'd3) begin errors++; $display("FAIL single_flit_cnt got %0d want 3", flit_cnt); end
    tick();
  endtask

  task automatic test_wrap();
    int n = 0;
    src_left[0] = 1; s_op1[0] = 25'h1FFFFFF; s_op2[0] = 25'h0000001;
    drive_inputs();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        n++;
        checks += 2;
        if (res_sum !== 25'h0000000) begin errors++; $display("FAIL wrap_sum got %h want 0000000", res_sum); end
        if (res_last !== 1'b1) begin errors++; $display("FAIL wrap_last got %b want 1", res_last); end
      end
      tick();
    end
    @(negedge clk);
    checks += 2;
    if (n != 1) begin errors++; $display("FAIL wrap_count got %0d want 1", n); end
    if (flit_cnt !== 32'd4) begin errors++; $display("FAIL wrap_flit_cnt got %0d want 4", flit_cnt); end
    tick();
  endtask

  task automatic test_round_robin();
    int gc[$], go[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < NREQ; k++) begin src_left[k] = (k == 0) ? 2 : 1; src_single[k] = 1; end
    drive_inputs();
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++)
        if (req_ready[k] === 1'b1) begin gc.push_back(c); go.push_back(k); end
      tick();
    end
    checks++;
    if (go.size() != 5) begin errors++; $display("FAIL rr_grants got %0d want 5", go.size()); end
    for (int i = 0; i < go.size() && i < 5; i++) begin
      checks += 2;
      if (go[i] != exp_order[i]) begin errors++; $display("FAIL rr_owner%0d got %0d want %0d", i, go[i], exp_order[i]); end
      if (gc[i] != 2 + 2 * i) begin errors++; $display("FAIL rr_cycle%0d got %0d want %0d", i, gc[i], 2 + 2 * i); end
    end
  endtask

  task automatic test_forced_release();
    int ids[$];
    int want;
    do_reset();
    src_left[1] = 25; src_nolast[1] = 1; src_left[2] = 1;
    drive_inputs();
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1) ids.push_back(int'(res_id));
      tick();
    end
    checks += 2;
    if (ids.size() != 26) begin errors++; $display("FAIL force_count got %0d want 26", ids.size()); end
    if (busy !== 1'b1) begin errors++; $display("FAIL force_hold_grant got %b want 1", busy); end
    for (int i = 0; i < ids.size() && i < 26; i++) begin
      want = (i == 20) ? 2 : 1;
      checks++;
      if (ids[i] != want) begin errors++; $display("FAIL force_id%0d got %0d want %0d", i, ids[i], want); end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] got[$];
    logic [N-1:0] hs;
    logic [IDW-1:0] hid;
    do_reset();
    sb_q.delete(); sb_on = 1; src_rand = 1;
    src_left[0] = 8; s_op1[0] = N'($urandom); s_op2[0] = N'($urandom);
    drive_inputs();
    for (int c = 1; c <= 20; c++) begin
      res_ready = !(c >= 5 && c <= 8);
      @(negedge clk);
      if (c == 5) begin hs = res_sum; hid = res_id; end
      if (c >= 5 && c <= 8) begin
        checks += 4;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b want 1", c, res_valid); end
        if (req_ready !== '0) begin errors++; $display("FAIL bp_ready c%0d got %b want 0", c, req_ready); end
        if (res_sum !== hs) begin errors++; $display("FAIL bp_sum c%0d got %h want %h", c, res_sum, hs); end
        if (res_id !== hid) begin errors++; $display("FAIL bp_id c%0d got %0d want %0d", c, res_id, hid); end
      end
      if (res_valid === 1'b1 && res_ready) got.push_back(res_sum);
      tick();
    end
    res_ready = 1; sb_on = 0; src_rand = 0;
    checks++;
    if (got.size() != 8 || sb_q.size() != 8) begin
      errors++; $display("FAIL bp_count got %0d want %0d", got.size(), sb_q.size());
    end
    for (int i = 0; i < got.size() && i < sb_q.size(); i++) begin
      checks++;
      if (got[i] !== sb_q[i]) begin errors++; $display("FAIL bp_data%0d got %h want %h", i, got[i], sb_q[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    src_left[1] = 1; src_left[2] = 10; s_op1[2] = 25'h123; s_op2[2] = 25'h456;
    drive_inputs();
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) rst = 1;
      @(negedge clk);
      if (c == 5) begin
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmb_pre_ready got %b want 0100", req_ready); end
      end
      tick();
    end
    rst = 0;
    src_left[0] = 1; src_left[3] = 1;
    drive_inputs();
    @(negedge clk);
    checks += 4;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL rmb_res_valid got %b want 0", res_valid); end
    if (flit_cnt !== 32'd0) begin errors++; $display("FAIL rmb_flit_cnt got %0d want 0", flit_cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rmb_busy got %b want 0", busy); end
    if (req_ready !== '0) begin errors++; $display("FAIL rmb_ready got %b want 0", req_ready); end
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmb_restart got %b want 0001", req_ready); end
    tick();
  endtask

  task automatic test_random();
    logic [65:0] act, exp;
    do_reset();
    src_rand = 1;
    for (int k = 0; k < NREQ; k++) begin s_op1[k] = N'($urandom); s_op2[k] = N'($urandom); end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (src_left[k] == 0 && $urandom_range(0, 3) == 0) src_left[k] = $urandom_range(1, 30);
        src_hold[k] = ($urandom_range(0, 4) == 0);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      drive_inputs();
      @(negedge clk);
      act = {req_ready, res_valid, res_sum, res_id, res_last, busy, flit_cnt};
      exp = {m_ready_f(), m_rv, m_sum, IDW'(m_id), m_last, m_locked, m_flits};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL rand_cycle%0d got %h want %h", c, act, exp); end
      tick();
    end
    rst = 0; res_ready = 1;
  endtask

  initial begin
    rst = 1; res_ready = 1;
    clear_sources(); drive_inputs();
    test_reset();
    test_single_packet();
    test_wrap();
    test_round_robin();
    test_forced_release();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
